// File: rtl/udp_pkg.sv
// UDP framing types, constants and header byte selection
// shared by the transmit framer and its neighbours.
package udp_pkg;

    localparam int UDP_HDR_LEN = 8;

    localparam logic [15:0] UDP_SRC_PORT_DEF = 16'd5000;
    localparam logic [15:0] UDP_DST_PORT_DEF = 16'd5001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } udp_state_e;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
    } udp_hdr_t;

    // Wire order of the 8 header bytes; checksum is always zero.
    function automatic logic [7:0] udp_hdr_byte(
        input logic [2:0] idx,
        input udp_hdr_t   h
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = h.src[15:8];
            3'd1:    b = h.src[7:0];
            3'd2:    b = h.dst[15:8];
            3'd3:    b = h.dst[7:0];
            3'd4:    b = h.len[15:8];
            3'd5:    b = h.len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_tx_framer.sv
// UDP datagram framer: emits the 8-byte header, then streams
// payload bytes from upstream onto a registered output stream.
module udp_tx_framer #(
    parameter int LEN_W       = 11,
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      src_port,
    input  logic [15:0]      dst_port,
    input  logic [LEN_W-1:0] payload_len,
    output logic             busy,
    output logic             err,
    output logic             done,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    import udp_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    udp_state_e       state_q;
    udp_state_e       state_d;
    udp_hdr_t         hdr_q;
    udp_hdr_t         hdr_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;

    logic [7:0]       data_d;
    logic             valid_d;
    logic             last_d;
    logic             busy_d;
    logic             err_d;
    logic             done_d;

    logic             load;
    logic             last_hs;
    logic             start_ok;
    logic             pay_take;
    logic [15:0]      udp_len;

    assign load     = !out_valid || out_ready;
    assign last_hs  = out_valid && out_ready && out_last;
    assign start_ok = start && (payload_len <= MAX_LEN);
    assign pay_take = (state_q == PAY) && load && (rem_q != '0);
    assign udp_len  = 16'(UDP_HDR_LEN) + 16'(payload_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (last_hs) begin
                    state_d = IDLE;
                end else if (!out_last && load &&
                             idx_q == 3'd7 && rem_q != '0) begin
                    state_d = PAY;
                end
            end
            PAY: begin
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_d    = hdr_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        data_d   = out_data;
        valid_d  = out_valid;
        last_d   = out_last;
        busy_d   = busy;
        err_d    = 1'b0;
        done_d   = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    // Header byte 0 goes out on the accepting edge.
                    hdr_d.src = src_port;
                    hdr_d.dst = dst_port;
                    hdr_d.len = udp_len;
                    data_d    = udp_hdr_byte(3'd0, hdr_d);
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                    idx_d     = 3'd1;
                    rem_d     = payload_len;
                    busy_d    = 1'b1;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            HDR: begin
                if (last_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!out_last && load) begin
                    data_d  = udp_hdr_byte(idx_q, hdr_q);
                    valid_d = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    last_d  = (idx_q == 3'd7) && (rem_q == '0);
                end
            end
            PAY: begin
                in_ready = pay_take;
                if (last_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (pay_take && in_valid) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                    rem_d   = rem_q - ONE;
                    last_d  = (rem_q == ONE);
                end else if (load) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q     <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            busy      <= busy_d;
            err       <= err_d;
            done      <= done_d;
        end
    end

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Parametrised UDP datagram framer: on `start`, latches source port, destination port and payload length.
- Emits the 8-byte UDP header (length computed, checksum 0x0000), then streams payload bytes pulled from an upstream valid/ready byte stream.
- Output is a registered byte stream with valid/ready/last, feeding the IPv4 encapsulation stage.
- Supports runtime ports and lengths, backpressure and zero-length datagrams.

Parameters:
- LEN_W, 11: width of the `payload_len` input in bits.
- MAX_PAYLOAD, 1472: largest accepted payload in bytes. Must be ≤ 2^LEN_W − 1 and ≤ 65527.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_port  in  16  UDP source port; latched on accepted start.
- dst_port  in  16  UDP destination port; latched on accepted start.
- payload_len  in  LEN_W  payload byte count; latched on accepted start.
- busy  out  1  high from accepted start until the last byte is handshaken.
- err  out  1  one-cycle pulse when a start is rejected (`payload_len` > MAX_PAYLOAD).
- done  out  1  one-cycle pulse in the cycle after the last byte handshake.
- in_data  in  8  payload byte.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  framer accepts `in_data` this cycle.
- out_data  out  8  datagram byte.
- out_valid  out  1  `out_data` valid.
- out_last  out  1  marks the final byte of the datagram.
- out_ready  in  1  downstream accepts this cycle.

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE
  - busy, err, done, in_ready, out_valid, out_last = 0
  - out_data = 0x00
  - byte counters = 0
- Handshakes:
  - Output transfer happens on `out_valid` && `out_ready`. `out_data`, `out_valid` and `out_last` stay stable while `out_valid` && !`out_ready`.
  - Input transfer happens on `in_valid` && `in_ready`.
- Output register load condition: `load` = !`out_valid` || `out_ready`.
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - `start` with `payload_len` ≤ MAX_PAYLOAD: latch the fields, compute udp_len = 8 + `payload_len` (16-bit, no overflow by parameter constraint), set busy = 1, go to HDR with hdr_idx = 0.
  - `start` with `payload_len` > MAX_PAYLOAD: err = 1 for one cycle, remain IDLE.
- HDR:
  - On each `load`, drive header byte hdr_idx in this order: src MSB, src LSB, dst MSB, dst LSB, len MSB, len LSB, 0x00, 0x00.
  - Start-to-first-byte latency: first header byte is valid the cycle after `start`.
  - After byte 7 is loaded:
    - `payload_len` == 0: `out_last` = 1 on byte 7; the FSM stays waiting until that byte handshakes.
    - Otherwise: go to PAY with remaining = `payload_len`.
- PAY:
  - in_ready = `load` && remaining ≠ 0 (combinational).
  - On an input transfer: `out_data` ← `in_data`, `out_valid` = 1, remaining −1; `out_last` = 1 when remaining was 1.
  - On `load` with no input transfer: `out_valid` ← 0 (bubble allowed).
- Completion: when the `out_last` byte handshakes, clear `out_valid`/`out_last`, busy = 0, go to IDLE, and pulse done the next cycle.
- `start` while busy is ignored: no err, no effect.
- Throughput: 1 byte/cycle with `out_ready` held high and `in_valid` held high. No gap between header byte 7 and payload byte 0.
- `in_ready` is never high outside PAY.
- Reset mid-datagram aborts immediately. No partial-frame recovery: downstream discards on reset.

Decomposition:
- Package udp_pkg holds:
  - UDP_HDR_LEN = 8
  - state enum {IDLE, HDR, PAY}
  - default port constants UDP_SRC_PORT_DEF = 5000, UDP_DST_PORT_DEF = 5001
  - a header-byte-select function (index → byte from ports/length)
- No sub-module required. An optional `udp_out_reg` holds the output-register/load logic if it is shared with the IPv4 stage.

Test Plan:
- src = 5000, dst = 5001, len = 11, payload "Hello World", `out_ready` = 1, `in_valid` = 1 → 19 consecutive bytes:
  - header 13 88 13 89 00 13 00 00
  - payload 48 65 6C 6C 6F 20 57 6F 72 6C 64
  - `out_last` only on 0x64, busy for 19 cycles, done one cycle later.
- Same datagram with `out_ready` toggling 1,0,0,1… → identical byte sequence; bytes held stable during stalls; no `in_data` consumed while stalled.
- len = 0, src = 0x0400, dst = 0x0035 → 04 00 00 35 00 08 00 00 with `out_last` on byte 7; `in_ready` stays 0 throughout.
- len = 1473 → err pulses one cycle, busy stays 0, no output. A following len = 4 start is accepted normally.
- Second `start` issued mid-payload with different ports → ignored; the in-progress datagram completes unchanged.
- Assert `rst_n` low during payload byte 5 → all outputs go to reset values immediately. The next `start` produces a correct full datagram.
